// File: rtl/decode_stage.sv
// decode_stage
// Handshaked MIPS-subset instruction decoder. It takes one instruction per
// cycle and, one cycle later, presents a registered control bundle. A lw that
// is still in the output register, or one that left in the previous cycle,
// blocks any incoming instruction that reads its destination.
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high. The source holds valid and its data stable until that transfer. The
// valid signal never depends on ready.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     upstream handshake, in_instr = instruction word
//   out_valid/out_ready   downstream handshake for the decoded bundle
//   out_alu_func          001 add, 010 sub, 011 and, 100 or, 101 slt, 000 none
//   out_rs/out_rt/out_rd  source and destination register indices
//   out_reg_write         destination is written
//   out_imm/out_use_imm   extended immediate (or jump target), ALU B select
//   out_mem_load/out_mem_write/out_jump/out_branch/out_branch_ne  class flags
//   out_illegal           unrecognised opcode or funct
//   stall_cnt             saturating count of hazard-stall cycles
module decode_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_AW     = 5,
  parameter int LOGIC_ZEXT = 1,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [31:0]       in_instr,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        out_alu_func,
  output logic [REG_AW-1:0] out_rs,
  output logic [REG_AW-1:0] out_rt,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_reg_write,
  output logic [DATA_W-1:0] out_imm,
  output logic              out_use_imm,
  output logic              out_mem_load,
  output logic              out_mem_write,
  output logic              out_jump,
  output logic              out_branch,
  output logic              out_branch_ne,
  output logic              out_illegal,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [2:0] ALU_NONE = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_OR   = 3'b100;
  localparam logic [2:0] ALU_SLT  = 3'b101;

  // ---------------------------------------------------------------------
  // Field extraction
  // ---------------------------------------------------------------------
  logic [5:0]        op;
  logic [5:0]        funct;
  logic [REG_AW-1:0] f_rs;
  logic [REG_AW-1:0] f_rt;
  logic [REG_AW-1:0] f_rd;
  logic [DATA_W-1:0] imm_sext;
  logic [DATA_W-1:0] imm_zext;
  logic [DATA_W-1:0] imm_jext;

  assign op       = in_instr[31:26];
  assign funct    = in_instr[5:0];
  assign f_rs     = REG_AW'(in_instr[25:21]);
  assign f_rt     = REG_AW'(in_instr[20:16]);
  assign f_rd     = REG_AW'(in_instr[15:11]);
  assign imm_sext = {{(DATA_W-16){in_instr[15]}}, in_instr[15:0]};
  assign imm_zext = {{(DATA_W-16){1'b0}}, in_instr[15:0]};
  assign imm_jext = {{(DATA_W-26){1'b0}}, in_instr[25:0]};

  // ---------------------------------------------------------------------
  // Combinational decode of the incoming instruction
  // ---------------------------------------------------------------------
  logic [2:0]        d_alu;
  logic [REG_AW-1:0] d_rd;
  logic              d_rw;
  logic [DATA_W-1:0] d_imm;
  logic              d_use_imm;
  logic              d_load;
  logic              d_store;
  logic              d_jump;
  logic              d_branch;
  logic              d_branch_ne;
  logic              d_illegal;

  always_comb begin
    d_alu       = ALU_NONE;
    d_rd        = '0;
    d_rw        = 1'b0;
    d_imm       = imm_sext;
    d_use_imm   = 1'b0;
    d_load      = 1'b0;
    d_store     = 1'b0;
    d_jump      = 1'b0;
    d_branch    = 1'b0;
    d_branch_ne = 1'b0;
    d_illegal   = 1'b0;
    case (op)
      6'h00: begin
        case (funct)
          6'h20:   d_alu = ALU_ADD;
          6'h22:   d_alu = ALU_SUB;
          6'h24:   d_alu = ALU_AND;
          6'h25:   d_alu = ALU_OR;
          6'h2A:   d_alu = ALU_SLT;
          default: d_illegal = 1'b1;
        endcase
        if (!d_illegal) begin
          d_rw = 1'b1;
          d_rd = f_rd;
        end
      end
      6'h08, 6'h0A, 6'h0C, 6'h0D: begin
        d_use_imm = 1'b1;
        d_rw      = 1'b1;
        d_rd      = f_rt;
        case (op)
          6'h08:   d_alu = ALU_ADD;
          6'h0A:   d_alu = ALU_SLT;
          6'h0C:   d_alu = ALU_AND;
          default: d_alu = ALU_OR;
        endcase
        // Logical immediates optionally treat the field as unsigned.
        if ((op == 6'h0C || op == 6'h0D) && LOGIC_ZEXT != 0) d_imm = imm_zext;
      end
      6'h23: begin
        d_alu     = ALU_ADD;
        d_use_imm = 1'b1;
        d_rw      = 1'b1;
        d_rd      = f_rt;
        d_load    = 1'b1;
      end
      6'h2B: begin
        d_alu     = ALU_ADD;
        d_use_imm = 1'b1;
        d_store   = 1'b1;
      end
      6'h04, 6'h05: begin
        d_alu       = ALU_SUB;
        d_branch    = 1'b1;
        d_branch_ne = (op == 6'h05);
      end
      6'h02: begin
        d_jump = 1'b1;
        d_imm  = imm_jext;
      end
      default: d_illegal = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------
  // Load-use hazard detection
  // ---------------------------------------------------------------------
  logic [REG_AW-1:0] bubble_dst;   // lw destination that left last cycle
  logic [REG_AW-1:0] held_lw_dst;  // lw destination still in the output reg
  logic              reads_rs;
  logic              reads_rt;
  logic              hit_held;
  logic              hit_bubble;
  logic              hazard;
  logic              xfer_in;
  logic              xfer_out;

  assign reads_rs    = (op != 6'h02);
  assign reads_rt    = (op == 6'h00) || (op == 6'h2B) || (op == 6'h04) || (op == 6'h05);
  assign held_lw_dst = (out_valid && out_mem_load) ? out_rd : '0;

  // A zero destination never matches, so $0 can never stall the pipe.
  assign hit_held   = (held_lw_dst != '0) &&
                      ((reads_rs && f_rs == held_lw_dst) || (reads_rt && f_rt == held_lw_dst));
  assign hit_bubble = (bubble_dst != '0) &&
                      ((reads_rs && f_rs == bubble_dst) || (reads_rt && f_rt == bubble_dst));
  assign hazard     = in_valid && (hit_held || hit_bubble);

  assign in_ready = (!out_valid || out_ready) && !hazard;
  assign xfer_in  = in_valid && in_ready;
  assign xfer_out = out_valid && out_ready;

  // ---------------------------------------------------------------------
  // Output register, bubble register, stall counter
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_alu_func  <= ALU_NONE;
      out_rs        <= '0;
      out_rt        <= '0;
      out_rd        <= '0;
      out_reg_write <= 1'b0;
      out_imm       <= '0;
      out_use_imm   <= 1'b0;
      out_mem_load  <= 1'b0;
      out_mem_write <= 1'b0;
      out_jump      <= 1'b0;
      out_branch    <= 1'b0;
      out_branch_ne <= 1'b0;
      out_illegal   <= 1'b0;
      bubble_dst    <= '0;
      stall_cnt     <= '0;
    end else begin
      if (xfer_in) begin
        out_valid     <= 1'b1;
        out_alu_func  <= d_alu;
        out_rs        <= f_rs;
        out_rt        <= f_rt;
        out_rd        <= d_rd;
        out_reg_write <= d_rw;
        out_imm       <= d_imm;
        out_use_imm   <= d_use_imm;
        out_mem_load  <= d_load;
        out_mem_write <= d_store;
        out_jump      <= d_jump;
        out_branch    <= d_branch;
        out_branch_ne <= d_branch_ne;
        out_illegal   <= d_illegal;
      end else if (xfer_out) begin
        out_valid <= 1'b0;
      end
      // Lives for exactly one cycle after a lw leaves the stage.
      bubble_dst <= (xfer_out && out_mem_load) ? out_rd : '0;
      if (hazard && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

  typedef struct packed {
    logic [2:0]  alu;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] imm;
    logic        ui;
    logic        ml;
    logic        mw;
    logic        j;
    logic        b;
    logic        bne;
    logic        ill;
  } bundle_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_alu_func;
  logic [4:0]  out_rs, out_rt, out_rd;
  logic        out_reg_write;
  logic [31:0] out_imm;
  logic        out_use_imm;
  logic        out_mem_load, out_mem_write, out_jump, out_branch, out_branch_ne;
  logic        out_illegal;
  logic [15:0] stall_cnt;

  decode_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_func(out_alu_func), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
    .out_reg_write(out_reg_write), .out_imm(out_imm), .out_use_imm(out_use_imm),
    .out_mem_load(out_mem_load), .out_mem_write(out_mem_write), .out_jump(out_jump),
    .out_branch(out_branch), .out_branch_ne(out_branch_ne), .out_illegal(out_illegal),
    .stall_cnt(stall_cnt)
  );

  bundle_t dut_b;
  always_comb begin
    dut_b     = '0;
    dut_b.alu = out_alu_func;
    dut_b.rs  = out_rs;
    dut_b.rt  = out_rt;
    dut_b.rd  = out_rd;
    dut_b.rw  = out_reg_write;
    dut_b.imm = out_imm;
    dut_b.ui  = out_use_imm;
    dut_b.ml  = out_mem_load;
    dut_b.mw  = out_mem_write;
    dut_b.j   = out_jump;
    dut_b.b   = out_branch;
    dut_b.bne = out_branch_ne;
    dut_b.ill = out_illegal;
  end

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  logic        m_valid;
  bundle_t     m_b;
  logic [4:0]  m_bubble;
  logic [15:0] m_cnt;
  logic        m_xin;
  logic [31:0] exp_q[$];

  // Decode table straight from the instruction-set description.
  function automatic bundle_t ref_decode(logic [31:0] ins);
    bundle_t b;
    logic [5:0] op;
    op    = ins[31:26];
    b     = '0;
    b.rs  = ins[25:21];
    b.rt  = ins[20:16];
    b.imm = 32'($signed(ins[15:0]));
    case (op)
      6'h00: begin
        case (ins[5:0])
          6'h20: b.alu = 3'd1;
          6'h22: b.alu = 3'd2;
          6'h24: b.alu = 3'd3;
          6'h25: b.alu = 3'd4;
          6'h2A: b.alu = 3'd5;
          default: b.ill = 1'b1;
        endcase
        if (!b.ill) begin b.rw = 1'b1; b.rd = ins[15:11]; end
      end
      6'h08: begin b.alu = 3'd1; b.ui = 1; b.rw = 1; b.rd = ins[20:16]; end
      6'h0A: begin b.alu = 3'd5; b.ui = 1; b.rw = 1; b.rd = ins[20:16]; end
      6'h0C: begin b.alu = 3'd3; b.ui = 1; b.rw = 1; b.rd = ins[20:16]; b.imm = {16'h0, ins[15:0]}; end
      6'h0D: begin b.alu = 3'd4; b.ui = 1; b.rw = 1; b.rd = ins[20:16]; b.imm = {16'h0, ins[15:0]}; end
      6'h23: begin b.alu = 3'd1; b.ui = 1; b.rw = 1; b.rd = ins[20:16]; b.ml = 1; end
      6'h2B: begin b.alu = 3'd1; b.ui = 1; b.mw = 1; end
      6'h04: begin b.alu = 3'd2; b.b = 1; end
      6'h05: begin b.alu = 3'd2; b.b = 1; b.bne = 1; end
      6'h02: begin b.j = 1; b.imm = {6'h0, ins[25:0]}; end
      default: b.ill = 1'b1;
    endcase
    return b;
  endfunction

  // Hazard: any nonzero source read by the instruction equals any pending
  // load destination (held lw or lw that just left).
  function automatic logic ref_hazard(logic v, logic [31:0] ins);
    logic [4:0] srcs[$];
    logic [4:0] dsts[$];
    logic [5:0] op;
    logic hz;
    op = ins[31:26];
    hz = 1'b0;
    if (op != 6'h02) srcs.push_back(ins[25:21]);
    if (op == 6'h00 || op == 6'h2B || op == 6'h04 || op == 6'h05) srcs.push_back(ins[20:16]);
    dsts.push_back(m_bubble);
    if (m_valid && m_b.ml) dsts.push_back(m_b.rd);
    foreach (srcs[i]) foreach (dsts[k])
      if (srcs[i] != 0 && srcs[i] == dsts[k]) hz = 1'b1;
    return v && hz;
  endfunction

  function automatic logic ref_in_ready();
    return (!m_valid || out_ready) && !ref_hazard(in_valid, in_instr);
  endfunction

  task automatic model_reset();
    m_valid  = 1'b0;
    m_b      = '0;
    m_bubble = '0;
    m_cnt    = '0;
    m_xin    = 1'b0;
    exp_q.delete();
  endtask

  // Advance one clock; DUT and model both take the edge.
  task automatic step();
    logic hz, xin, xout;
    hz   = ref_hazard(in_valid, in_instr);
    xin  = in_valid && (!m_valid || out_ready) && !hz;
    xout = m_valid && out_ready;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      m_bubble = (xout && m_b.ml) ? m_b.rd : 5'd0;
      if (hz && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      if (xin) begin
        m_valid = 1'b1;
        m_b     = ref_decode(in_instr);
        exp_q.push_back(in_instr);
      end else if (xout) begin
        m_valid = 1'b0;
      end
      m_xin = xin;
    end
    #1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    exp_q.delete();
  endtask

  // ------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;
    model_reset();
    step();
    step();
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_cmp++; if (dut_b !== '0) begin n_bad++; $display("FAIL reset_bundle: got %h want 0", dut_b); end
    n_cmp++; if (stall_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_add();
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h00221820;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL add_in_ready: got %b want 1", in_ready); end
    step();
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL add_valid: got %b want 1", out_valid); end
    n_cmp++;
    if ({out_alu_func, out_rs, out_rt, out_rd, out_reg_write, out_use_imm} !== {3'b001, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL add_fields: got alu=%b rs=%0d rt=%0d rd=%0d rw=%b ui=%b want 001/1/2/3/1/0",
               out_alu_func, out_rs, out_rt, out_rd, out_reg_write, out_use_imm);
    end
    step();
  endtask

  task automatic test_imm();
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h2005FFFF;
    step();
    in_instr = 32'h34058000;
    @(negedge clk);
    n_cmp++; if (out_imm !== 32'hFFFFFFFF || out_rd !== 5'd5 || out_alu_func !== 3'b001)
      begin n_bad++; $display("FAIL addi: got imm=%h rd=%0d alu=%b want ffffffff/5/001", out_imm, out_rd, out_alu_func); end
    step();
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (out_imm !== 32'h00008000 || out_alu_func !== 3'b100 || out_use_imm !== 1'b1)
      begin n_bad++; $display("FAIL ori: got imm=%h alu=%b ui=%b want 00008000/100/1", out_imm, out_alu_func, out_use_imm); end
    step();
  endtask

  task automatic test_load_use();
    logic [15:0] c0;
    int held;
    drain();
    c0 = m_cnt;
    in_valid = 1'b1; in_instr = 32'h8C240008;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL lw_accept: got %b want 1", in_ready); end
    step();
    in_instr = 32'h00823020;
    held = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (in_ready === 1'b1) break;
      held++;
      step();
    end
    n_cmp++; if (held != 2) begin n_bad++; $display("FAIL load_use_held: got %0d cycles want 2", held); end
    step();
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (stall_cnt !== c0 + 16'd2) begin n_bad++; $display("FAIL load_use_cnt: got %0d want %0d", stall_cnt, c0 + 16'd2); end
    n_cmp++; if (out_valid !== 1'b1 || dut_b !== ref_decode(32'h00823020))
      begin n_bad++; $display("FAIL load_use_out: got v=%b %h want v=1 %h", out_valid, dut_b, ref_decode(32'h00823020)); end
    step();
  endtask

  task automatic test_backpressure();
    logic [31:0] seq[5];
    seq = '{32'h00221820, 32'h34058000, 32'h00642822, 32'h0022382A, 32'hAC220004};
    drain();
    out_ready = 1'b0; in_valid = 1'b1; in_instr = seq[0];
    step();
    in_instr = seq[1];
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); end
      n_cmp++; if (out_valid !== 1'b1 || dut_b !== ref_decode(seq[0]))
        begin n_bad++; $display("FAIL bp_hold[%0d]: got v=%b %h want v=1 %h", i, out_valid, dut_b, ref_decode(seq[0])); end
      step();
    end
    out_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      in_instr = seq[i];
      @(negedge clk);
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release_ready[%0d]: got %b want 1", i, in_ready); end
      n_cmp++; if (out_valid !== 1'b1 || dut_b !== ref_decode(seq[i-1]))
        begin n_bad++; $display("FAIL bp_stream[%0d]: got v=%b %h want %h", i, out_valid, dut_b, ref_decode(seq[i-1])); end
      step();
    end
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1 || dut_b !== ref_decode(seq[4]))
      begin n_bad++; $display("FAIL bp_last: got v=%b %h want %h", out_valid, dut_b, ref_decode(seq[4])); end
    step();
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_empty: got %b want 0", out_valid); end
  endtask

  task automatic test_branch_jump_illegal();
    drain();
    in_valid = 1'b1; in_instr = 32'h1022FFFE;
    step();
    in_instr = 32'h08000010;
    @(negedge clk);
    n_cmp++; if (out_branch !== 1'b1 || out_alu_func !== 3'b010 || out_imm !== 32'hFFFFFFFE || out_reg_write !== 1'b0)
      begin n_bad++; $display("FAIL beq: got b=%b alu=%b imm=%h rw=%b want 1/010/fffffffe/0", out_branch, out_alu_func, out_imm, out_reg_write); end
    step();
    in_instr = 32'h0000003F;
    @(negedge clk);
    n_cmp++; if (out_jump !== 1'b1 || out_imm !== 32'h00000010 || out_alu_func !== 3'b000)
      begin n_bad++; $display("FAIL j: got j=%b imm=%h alu=%b want 1/00000010/000", out_jump, out_imm, out_alu_func); end
    step();
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (out_illegal !== 1'b1 || out_alu_func !== 3'b000 || out_reg_write !== 1'b0 || out_jump !== 1'b0 || out_branch !== 1'b0)
      begin n_bad++; $display("FAIL illegal: got ill=%b alu=%b rw=%b j=%b b=%b want 1/000/0/0/0", out_illegal, out_alu_func, out_reg_write, out_jump, out_branch); end
    step();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0]  s, t, d;
    logic [15:0] im;
    s  = 5'($urandom_range(0, 3));
    t  = 5'($urandom_range(0, 3));
    d  = 5'($urandom_range(0, 3));
    im = 16'($urandom);
    case ($urandom_range(0, 16))
      0:  return {6'h00, s, t, d, 5'd0, 6'h20};
      1:  return {6'h00, s, t, d, 5'd0, 6'h22};
      2:  return {6'h00, s, t, d, 5'd0, 6'h24};
      3:  return {6'h00, s, t, d, 5'd0, 6'h25};
      4:  return {6'h00, s, t, d, 5'd0, 6'h2A};
      5:  return {6'h08, s, t, im};
      6:  return {6'h0A, s, t, im};
      7:  return {6'h0C, s, t, im};
      8:  return {6'h0D, s, t, im};
      9, 10, 11: return {6'h23, s, t, im};
      12: return {6'h2B, s, t, im};
      13: return {6'h04, s, t, im};
      14: return {6'h05, s, t, im};
      15: return {6'h02, 26'($urandom)};
      default: return {6'h3F, s, t, im};
    endcase
  endfunction

  task automatic test_random();
    logic [31:0] e;
    drain();
    for (int c = 0; c < 500; c++) begin
      if (!in_valid || m_xin) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_instr = rand_instr();
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      n_cmp++; if (in_ready !== ref_in_ready())
        begin n_bad++; $display("FAIL rnd_in_ready@%0d: got %b want %b", c, in_ready, ref_in_ready()); end
      n_cmp++; if (out_valid !== m_valid || dut_b !== m_b)
        begin n_bad++; $display("FAIL rnd_bundle@%0d: got v=%b %h want v=%b %h", c, out_valid, dut_b, m_valid, m_b); end
      n_cmp++; if (stall_cnt !== m_cnt)
        begin n_bad++; $display("FAIL rnd_cnt@%0d: got %0d want %0d", c, stall_cnt, m_cnt); end
      if (out_valid === 1'b1 && out_ready && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++; if (dut_b !== ref_decode(e))
          begin n_bad++; $display("FAIL rnd_order@%0d: got %h want %h (instr %h)", c, dut_b, ref_decode(e), e); end
      end
      m_xin = 1'b0;
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    drain();
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h8C240008;
    step();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_valid: got %b want 0", out_valid); end
    n_cmp++; if (stall_cnt !== 16'd0) begin n_bad++; $display("FAIL rst_mid_cnt: got %0d want 0", stall_cnt); end
    n_cmp++; if (dut_b !== '0) begin n_bad++; $display("FAIL rst_mid_bundle: got %h want 0", dut_b); end
    model_reset();
    step();
    rst_n = 1'b1;
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h00823020;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_mid_no_hazard: got %b want 1", in_ready); end
    step();
    in_valid = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_add();
    test_imm();
    test_load_use();
    test_backpressure();
    test_branch_jump_illegal();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
